// File: rtl/data_pipe_pkg.sv
// Shared types and helpers for the data_pipe skid-buffered pipeline.
package data_pipe_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_HALF  = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_e;

  // Occupancy counter width: must represent 0..2*stages inclusive.
  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/data_pipe_if.sv
// Valid/ready/data handshake bundle used on both sides of the pipe.
interface data_pipe_if #(
  parameter int unsigned DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/data_pipe_skid_stage.sv
// One skid-buffered pipeline stage: main + skid register, registered ready.
module pipe_skid_stage
  import data_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              ready_q, ready_d;
  logic              push, pop;

  // Ready comes from a register; flush only masks it, so out_ready never reaches in_ready.
  assign in_ready  = ready_q & ~flush;
  assign push      = in_valid & in_ready;
  assign out_valid = (state_q == SKID_HALF) || (state_q == SKID_FULL);
  assign pop       = out_valid & out_ready;
  assign out_data  = main_q;

  // Next-state and datapath selection for the main/skid pair.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      SKID_EMPTY: begin
        if (push) begin
          main_d  = in_data;
          state_d = SKID_HALF;
        end
      end
      SKID_HALF: begin
        if (push && !pop) begin
          skid_d  = in_data;
          state_d = SKID_FULL;
        end else if (pop && !push) begin
          state_d = SKID_EMPTY;
        end else if (push && pop) begin
          main_d  = in_data;
        end
      end
      SKID_FULL: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = SKID_HALF;
        end
      end
      default: begin
        state_d = SKID_EMPTY;
      end
    endcase
    if (flush) begin
      state_d = SKID_EMPTY;
    end
    ready_d = (state_d != SKID_FULL);
  end

  // State, data and ready registers; reset clears held data to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  a_legal_state : assert property (@(posedge clk) disable iff (!rst_n)
    state_q inside {SKID_EMPTY, SKID_HALF, SKID_FULL})
    else $error("pipe_skid_stage: illegal state encoding %b", state_q);

endmodule

// File: rtl/data_pipe.sv
// Back-pressurable pipeline of STAGES skid stages with a live occupancy count.
module data_pipe
  import data_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned STAGES = 2,
  localparam int unsigned OCC_W = occ_width(STAGES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  data_pipe_if.slave       in_if,
  data_pipe_if.master      out_if,
  output logic [OCC_W-1:0] occupancy
);

  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(2 * STAGES);

  logic [STAGES:0]   vld;
  logic [STAGES:0]   rdy;
  logic [DATA_W-1:0] dat [STAGES+1];
  logic              in_fire, out_fire;
  logic [OCC_W-1:0]  occ_q, occ_d;

  assign vld[0]       = in_if.valid;
  assign dat[0]       = in_if.data;
  assign in_if.ready  = rdy[0];
  assign out_if.valid = vld[STAGES];
  assign out_if.data  = dat[STAGES];
  assign rdy[STAGES]  = out_if.ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    pipe_skid_stage #(
      .DATA_W (DATA_W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (vld[i]),
      .in_ready  (rdy[i]),
      .in_data   (dat[i]),
      .out_valid (vld[i+1]),
      .out_ready (rdy[i+1]),
      .out_data  (dat[i+1])
    );
  end

  assign in_fire   = in_if.valid & in_if.ready;
  assign out_fire  = out_if.valid & out_if.ready;
  assign occupancy = occ_q;

  // Occupancy update: flush wins, otherwise net of input/output transfers, clamped.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_fire && !out_fire && (occ_q != OCC_MAX)) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (out_fire && !in_fire && (occ_q != '0)) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule
